// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between a requester and the bit-serial subtractor.
`default_nettype none

interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] D;
  logic             B_out;
  logic             busy;
  logic             done;

  modport master (output start, A, B, input D, B_out, busy, done);
  modport slave  (input start, A, B, output D, B_out, busy, done);
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B, LSB first, one full-subtractor cell plus a borrow flip-flop.
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bw_q, bw_d;
  logic             bout_q, bout_d;

  logic w_diff;
  logic w_borrow;

  assign w_diff   = ra_q[0] ^ rb_q[0] ^ bw_q;
  assign w_borrow = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & bw_q);

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    bw_d    = bw_q;
    bout_d  = bout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ra_d    = bus.A;
          rb_d    = bus.B;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ra_d  = {1'b0, ra_q[WIDTH-1:1]};
        rb_d  = {1'b0, rb_q[WIDTH-1:1]};
        res_d = {w_diff, res_q[WIDTH-1:1]};
        bw_d  = w_borrow;
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish the completed difference and the outgoing borrow together
        if (cnt_q == CW'(WIDTH - 1)) begin
          dout_d  = {w_diff, res_q[WIDTH-1:1]};
          bout_d  = w_borrow;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      bw_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      bw_q    <= bw_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.D     = dout_q;
  assign bus.B_out = bout_q;
  assign bus.busy  = (state_q == S_SHIFT);
  assign bus.done  = (state_q == S_DONE);
endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=4.
`default_nettype none

module tb_serial_subtractor;
  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   n_done;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle where done is high, or flags a timeout.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_d, input logic exp_bo, input string tag);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done();
    chk({tag, "_D"}, 32'(bus.D), 32'(exp_d));
    chk({tag, "_Bout"}, 32'(bus.B_out), 32'(exp_bo));
    tick();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    tick();
    tick();
    chk("rst_D", 32'(bus.D), 32'd0);
    chk("rst_Bout", 32'(bus.B_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    tick();

    run_op(4'b1011, 4'b1101, 4'b1110, 1'b1, "basic1");
    run_op(4'b1101, 4'b1011, 4'b0010, 1'b0, "basic2");
    run_op(4'b0000, 4'b1111, 4'b0001, 1'b1, "ext_0_f");
    run_op(4'b1111, 4'b0000, 4'b1111, 1'b0, "ext_f_0");
    run_op(4'b0110, 4'b0110, 4'b0000, 1'b0, "ext_eq");

    // Timing: 8-3=5, previous D is 0
    bus.A     = 4'd8;
    bus.B     = 4'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tim_busy%0d", k), 32'(bus.busy), 32'd1);
      chk($sformatf("tim_done%0d", k), 32'(bus.done), 32'd0);
      chk($sformatf("tim_Dhold%0d", k), 32'(bus.D), 32'd0);
      tick();
    end
    chk("tim_busy_end", 32'(bus.busy), 32'd0);
    chk("tim_done_end", 32'(bus.done), 32'd1);
    chk("tim_D", 32'(bus.D), 32'd5);
    tick();
    chk("tim_done_off", 32'(bus.done), 32'd0);

    // Ignore: start with new operands mid-operation has no effect
    n_done    = 0;
    bus.A     = 4'd3;
    bus.B     = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.A     = 4'hF;
    bus.B     = 4'h0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done) begin
        n_done++;
        chk("ign_D", 32'(bus.D), 32'd2);
        chk("ign_Bout", 32'(bus.B_out), 32'd0);
      end
      tick();
    end
    chk("ign_done_count", 32'(n_done), 32'd1);

    // Reset mid-operation
    bus.A     = 4'd9;
    bus.B     = 4'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_D", 32'(bus.D), 32'd0);
    chk("mrst_Bout", 32'(bus.B_out), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op(4'd5, 4'd7, 4'hE, 1'b1, "post_rst");

    // Exhaustive with start held high
    bus.A     = 4'd0;
    bus.B     = 4'd0;
    bus.start = 1'b1;
    for (int p = 0; p < 256; p++) begin
      logic [3:0] a, b, ed;
      logic       eb;
      a  = 4'(p >> 4);
      b  = 4'(p);
      ed = 4'((int'(a) - int'(b) + 16) % 16);
      eb = (a < b);
      wait_done();
      chk($sformatf("exh_D_%0h_%0h", a, b), 32'(bus.D), 32'(ed));
      chk($sformatf("exh_Bout_%0h_%0h", a, b), 32'(bus.B_out), 32'(eb));
      bus.A = 4'((p + 1) >> 4);
      bus.B = 4'(p + 1);
    end
    bus.start = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
